cpu_register_file: RTL and testbench

- SLURM32 general-purpose register file: the reader/writer end of the decoder's register-select outputs.
- Accepts decoded regA/regB selects and returns operand data one cycle later.
- Accepts two writeback streams: ALU results and out-of-order load completions.
- Tracks pending load destinations in a scoreboard and raises a combinational hazard back to the decode/hazard stage.

---
 rtl/cpu_register_file.sv | 68 ++++++
 tb/tb_cpu_register_file.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cpu_register_file.sv
// cpu_register_file: SLURM32 two-write register file with write-first bypass and load scoreboard
module cpu_register_file #(
  parameter int BITS = 32,
  parameter int REGISTER_BITS = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [REGISTER_BITS-1:0] regA_sel,
  input  logic [REGISTER_BITS-1:0] regB_sel,
  output logic [BITS-1:0]          regA_data,
  output logic [BITS-1:0]          regB_data,
  input  logic                     alu_wr_en,
  input  logic [REGISTER_BITS-1:0] alu_wr_sel,
  input  logic [BITS-1:0]          alu_wr_data,
  input  logic                     ld_issue,
  input  logic [REGISTER_BITS-1:0] ld_issue_sel,
  input  logic                     ld_valid,
  input  logic [REGISTER_BITS-1:0] ld_wr_sel,
  input  logic [BITS-1:0]          ld_wr_data,
  output logic                     hazard,
  output logic                     loads_pending
);
  localparam int N = 1 << REGISTER_BITS;
  logic [BITS-1:0] mem [N];
  logic [N-1:0] pend, pend_next;
  logic alu_we, ld_we, ldhit_a, ldhit_b;
  logic [BITS-1:0] rd_a, rd_b;
  assign alu_we = alu_wr_en && alu_wr_sel != '0;
  assign ld_we = ld_valid && ld_wr_sel != '0;
  // ALU write is issued last so it wins a same-register collision
  always_ff @(posedge CLK) begin
    if (ld_we) mem[ld_wr_sel] <= ld_wr_data;
    if (alu_we) mem[alu_wr_sel] <= alu_wr_data;
  end
  always_comb begin
    rd_a = regA_sel == '0 ? '0
         : (alu_we && alu_wr_sel == regA_sel) ? alu_wr_data
         : (ld_we && ld_wr_sel == regA_sel) ? ld_wr_data
         : mem[regA_sel];
    rd_b = regB_sel == '0 ? '0
         : (alu_we && alu_wr_sel == regB_sel) ? alu_wr_data
         : (ld_we && ld_wr_sel == regB_sel) ? ld_wr_data
         : mem[regB_sel];
  end
  // clear before set so a same-cycle reissue keeps the register pending
  always_comb begin
    pend_next = pend;
    if (ld_valid) pend_next[ld_wr_sel] = 1'b0;
    if (ld_issue) pend_next[ld_issue_sel] = 1'b1;
    pend_next[0] = 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      regA_data <= '0;
      regB_data <= '0;
      pend <= '0;
      loads_pending <= 1'b0;
    end else begin
      regA_data <= rd_a;
      regB_data <= rd_b;
      pend <= pend_next;
      loads_pending <= |pend_next;
    end
  end
  assign ldhit_a = ld_valid && ld_wr_sel == regA_sel && !(ld_issue && ld_issue_sel == regA_sel);
  assign ldhit_b = ld_valid && ld_wr_sel == regB_sel && !(ld_issue && ld_issue_sel == regB_sel);
  assign hazard = (pend[regA_sel] && !ldhit_a) || (pend[regB_sel] && !ldhit_b);
endmodule

// File: tb/tb_cpu_register_file.sv
// tb_cpu_register_file: directed vectors for the SLURM32 register file
module tb_cpu_register_file;
  logic CLK = 0, RST = 0;
  logic [7:0] regA_sel, regB_sel, alu_wr_sel, ld_issue_sel, ld_wr_sel;
  logic [31:0] regA_data, regB_data, alu_wr_data, ld_wr_data;
  logic alu_wr_en, ld_issue, ld_valid, hazard, loads_pending;
  int vectors = 0, miscompares = 0;

  cpu_register_file dut (
    .CLK(CLK), .RST(RST),
    .regA_sel(regA_sel), .regB_sel(regB_sel),
    .regA_data(regA_data), .regB_data(regB_data),
    .alu_wr_en(alu_wr_en), .alu_wr_sel(alu_wr_sel), .alu_wr_data(alu_wr_data),
    .ld_issue(ld_issue), .ld_issue_sel(ld_issue_sel),
    .ld_valid(ld_valid), .ld_wr_sel(ld_wr_sel), .ld_wr_data(ld_wr_data),
    .hazard(hazard), .loads_pending(loads_pending)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    alu_wr_en = 0; ld_issue = 0; ld_valid = 0;
  endtask

  task automatic test_reset();
    idle(); regA_sel = 0; regB_sel = 0; alu_wr_sel = 0; alu_wr_data = 0;
    ld_issue_sel = 0; ld_wr_sel = 0; ld_wr_data = 0;
    RST = 1; tick(); tick(); RST = 0;
    vectors++; if (regA_data !== 32'h0) begin miscompares++; $display("FAIL reset_regA got %h exp 0", regA_data); end
    vectors++; if (regB_data !== 32'h0) begin miscompares++; $display("FAIL reset_regB got %h exp 0", regB_data); end
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %b exp 0", hazard); end
    vectors++; if (loads_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending got %b exp 0", loads_pending); end
  endtask

  task automatic test_basic_write();
    alu_wr_en = 1; alu_wr_sel = 5; alu_wr_data = 32'hDEADBEEF; tick();
    idle(); regA_sel = 5; regB_sel = 0; tick();
    vectors++; if (regA_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_r5 got %h exp deadbeef", regA_data); end
    vectors++; if (regB_data !== 32'h0) begin miscompares++; $display("FAIL read_r0 got %h exp 0", regB_data); end
  endtask

  task automatic test_bypass();
    alu_wr_en = 1; alu_wr_sel = 7; alu_wr_data = 32'h1234; regA_sel = 7; tick();
    vectors++; if (regA_data !== 32'h1234) begin miscompares++; $display("FAIL bypass_r7 got %h exp 1234", regA_data); end
    alu_wr_sel = 0; alu_wr_data = 32'hFFFFFFFF; regA_sel = 0; tick();
    vectors++; if (regA_data !== 32'h0) begin miscompares++; $display("FAIL bypass_r0 got %h exp 0", regA_data); end
    idle(); tick();
    vectors++; if (regA_data !== 32'h0) begin miscompares++; $display("FAIL read_r0_after_write got %h exp 0", regA_data); end
    regA_sel = 7; tick();
    vectors++; if (regA_data !== 32'h1234) begin miscompares++; $display("FAIL read_r7 got %h exp 1234", regA_data); end
  endtask

  task automatic test_load_hazard();
    ld_issue = 1; ld_issue_sel = 9; tick();
    idle(); regA_sel = 0; regB_sel = 9; #1;
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL hazard_r9 got %b exp 1", hazard); end
    vectors++; if (loads_pending !== 1'b1) begin miscompares++; $display("FAIL pending_r9 got %b exp 1", loads_pending); end
    ld_valid = 1; ld_wr_sel = 9; ld_wr_data = 32'hCAFE0001; #1;
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL hazard_release got %b exp 0", hazard); end
    tick(); idle();
    vectors++; if (regB_data !== 32'hCAFE0001) begin miscompares++; $display("FAIL load_bypass got %h exp cafe0001", regB_data); end
    vectors++; if (loads_pending !== 1'b0) begin miscompares++; $display("FAIL pending_cleared got %b exp 0", loads_pending); end
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL hazard_after_load got %b exp 0", hazard); end
  endtask

  task automatic test_collision();
    alu_wr_en = 1; alu_wr_sel = 3; alu_wr_data = 32'h11;
    ld_valid = 1; ld_wr_sel = 3; ld_wr_data = 32'h22; regA_sel = 3; regB_sel = 0; tick();
    vectors++; if (regA_data !== 32'h11) begin miscompares++; $display("FAIL collide_bypass got %h exp 11", regA_data); end
    idle(); tick();
    vectors++; if (regA_data !== 32'h11) begin miscompares++; $display("FAIL collide_array got %h exp 11", regA_data); end
    alu_wr_en = 1; alu_wr_sel = 3; alu_wr_data = 32'h33;
    ld_valid = 1; ld_wr_sel = 4; ld_wr_data = 32'h44; regA_sel = 0; tick();
    idle(); regA_sel = 3; regB_sel = 4; tick();
    vectors++; if (regA_data !== 32'h33) begin miscompares++; $display("FAIL dual_r3 got %h exp 33", regA_data); end
    vectors++; if (regB_data !== 32'h44) begin miscompares++; $display("FAIL dual_r4 got %h exp 44", regB_data); end
  endtask

  task automatic test_issue_and_valid();
    regA_sel = 0; regB_sel = 0;
    ld_issue = 1; ld_issue_sel = 9; tick();
    ld_valid = 1; ld_wr_sel = 9; ld_wr_data = 32'h77; regA_sel = 9; #1;
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL reissue_hazard_same got %b exp 1", hazard); end
    tick(); idle();
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL reissue_hazard_after got %b exp 1", hazard); end
    vectors++; if (loads_pending !== 1'b1) begin miscompares++; $display("FAIL reissue_pending got %b exp 1", loads_pending); end
    ld_valid = 1; ld_wr_sel = 9; ld_wr_data = 32'h88; tick(); idle();
    vectors++; if (loads_pending !== 1'b0) begin miscompares++; $display("FAIL reissue_cleared got %b exp 0", loads_pending); end
    vectors++; if (regA_data !== 32'h88) begin miscompares++; $display("FAIL reissue_data got %h exp 88", regA_data); end
  endtask

  task automatic test_r0_and_alu_no_clear();
    ld_issue = 1; ld_issue_sel = 0; regA_sel = 0; tick(); idle();
    vectors++; if (loads_pending !== 1'b0) begin miscompares++; $display("FAIL r0_issue_pending got %b exp 0", loads_pending); end
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL r0_issue_hazard got %b exp 0", hazard); end
    ld_issue = 1; ld_issue_sel = 10; tick(); idle();
    alu_wr_en = 1; alu_wr_sel = 10; alu_wr_data = 32'h99; regA_sel = 10; tick(); idle();
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL alu_no_clear_hazard got %b exp 1", hazard); end
    vectors++; if (loads_pending !== 1'b1) begin miscompares++; $display("FAIL alu_no_clear_pending got %b exp 1", loads_pending); end
    ld_valid = 1; ld_wr_sel = 10; ld_wr_data = 32'hAA; tick(); idle();
    vectors++; if (loads_pending !== 1'b0) begin miscompares++; $display("FAIL r10_cleared got %b exp 0", loads_pending); end
  endtask

  task automatic test_reset_mid_load();
    regA_sel = 0; regB_sel = 0;
    ld_issue = 1; ld_issue_sel = 12; tick(); idle();
    regA_sel = 12; #1;
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL r12_hazard got %b exp 1", hazard); end
    RST = 1; tick(); RST = 0;
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL rst_mid_hazard got %b exp 0", hazard); end
    vectors++; if (loads_pending !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pending got %b exp 0", loads_pending); end
    vectors++; if (regA_data !== 32'h0) begin miscompares++; $display("FAIL rst_mid_regA got %h exp 0", regA_data); end
    ld_valid = 1; ld_wr_sel = 12; ld_wr_data = 32'h55; regA_sel = 0; #1;
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL late_load_hazard got %b exp 0", hazard); end
    tick(); idle(); regA_sel = 12; tick();
    vectors++; if (regA_data !== 32'h55) begin miscompares++; $display("FAIL late_load_r12 got %h exp 55", regA_data); end
    vectors++; if (loads_pending !== 1'b0) begin miscompares++; $display("FAIL late_load_pending got %b exp 0", loads_pending); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bypass();
    test_load_hazard();
    test_collision();
    test_issue_and_valid();
    test_r0_and_alu_no_clear();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
